// File: rtl/ecs3_encoder.sv
// ECS3 index encoder: one byte in, one or two 4-index words out.
// Optional statistics counters: define ECS3_ENC_STATS_EN.
module ecs3_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       ind0,
  output logic [2:0]       ind1,
  output logic [2:0]       ind2,
  output logic [2:0]       ind3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef ECS3_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] split_count
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_bad
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    WL   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] word_q, word_d;
  logic [1:0]  pend_q, pend_d;

  logic [6:0]  lo_enc, hi_enc;
  logic [11:0] w1_word, w2_word;
  logic        split, accept;

  // Returns {split, even index, odd index} for one nibble.
  function automatic logic [6:0] enc_nib(input logic [3:0] n);
    logic [1:0] c0, c1;
    logic       sp;
    c0 = 2'b00;
    c1 = 2'b00;
    sp = 1'b0;
    unique case (n[2:0])
      3'b000: begin c0 = 2'b00; c1 = 2'b00; end
      3'b001: begin c0 = 2'b01; c1 = 2'b00; end
      3'b010: begin c0 = 2'b10; c1 = 2'b00; end
      3'b011: begin c0 = 2'b01; c1 = 2'b10; end
      3'b100: begin c0 = 2'b11; c1 = 2'b00; end
      3'b101: begin c0 = 2'b01; c1 = 2'b11; end
      3'b110: begin c0 = 2'b10; c1 = 2'b11; end
      3'b111: begin c0 = 2'b01; c1 = 2'b10; sp = 1'b1; end
      default: begin c0 = 2'b00; c1 = 2'b00; end
    endcase
    return {sp, n[3], c0, 1'b0, c1};
  endfunction

  always_comb begin
    lo_enc   = enc_nib(in_data[3:0]);
    hi_enc   = enc_nib(in_data[7:4]);
    w1_word  = {lo_enc[5:0], hi_enc[5:0]};
    split    = lo_enc[6] | hi_enc[6];
    w2_word  = {pend_q[0] ? 3'b011 : 3'b000, 3'b000,
                pend_q[1] ? 3'b011 : 3'b000, 3'b000};
    in_ready = (state_q == IDLE) |
               ((state_q == WL) & out_ready);
    accept   = in_valid & in_ready;

    state_d = state_q;
    word_d  = word_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: ;
      W1: begin
        if (out_ready) begin
          state_d = WL;
          word_d  = w2_word;
        end
      end
      WL: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = split ? W1 : WL;
      word_d  = w1_word;
      pend_d  = {hi_enc[6], lo_enc[6]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
    end
  end

  assign ind0      = word_q[11:9];
  assign ind1      = word_q[8:6];
  assign ind2      = word_q[5:3];
  assign ind3      = word_q[2:0];
  assign out_valid = (state_q != IDLE);
  assign out_last  = (state_q == WL);

`ifdef ECS3_ENC_STATS_EN
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    split_cnt_d = split_cnt_q;
    if (accept && (byte_cnt_q != '1))
      byte_cnt_d = byte_cnt_q + 1'b1;
    if (accept && split && (split_cnt_q != '1))
      split_cnt_d = split_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign byte_count  = byte_cnt_q;
  assign split_count = split_cnt_q;
`endif

endmodule

// File: doc/ecs3_encoder.md
Name: ecs3_encoder

Overview:
- Streaming encoder for the ECS3 index format. Takes one data byte per handshake and emits one or two ECS3 index words, each made of four 3-bit indices.
- Each index word is exactly what the ECS3 decoder consumes. The receiver ORs the decoded bytes of all words up to and including the out_last word, which reconstructs the input byte.
- Sits on the transmit side, between the byte source and the ECS3 link.

Parameters:
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  byte to encode
in_valid  in  1  in_data valid
in_ready  out  1  encoder accepts in_data this cycle
ind0  out  3  low nibble, index A, format {X,A,B}
ind1  out  3  low nibble, index B
ind2  out  3  high nibble, index A
ind3  out  3  high nibble, index B
out_valid  out  1  ind0..ind3 valid
out_ready  in  1  downstream accepts the word
out_last  out  1  final word of the current byte

Behaviour:
- Reset is asynchronous and active-low on rst_n. The block uses one clock, clk.
- Reset values: ind0..ind3=0, out_valid=0, out_last=0, in_ready=1, FSM=IDLE.
- Index code for one nibble bit:
  - bit0 -> AB=01; bit1 -> AB=10; bit2 -> AB=11; none -> AB=00.
  - X carries nibble bit3.
- Per nibble (low nibble -> ind0/ind1; high nibble -> ind2/ind3):
  - Let S = set bits among nibble bits 2..0, in ascending order.
  - Word 1: even index = {bit3, code(S[0])}; odd index = {0, code(S[1])}. A missing S entry codes as 00.
  - Word 2, only when |S|=3: even index = {0,11}; odd index = 000.
  - A nibble with |S|<=2 in a two-word byte emits 000/000 in word 2.
- Words per byte = 2 if either nibble has |S|=3, otherwise 1.
- X appears only in word 1. Redundant bits never repeat across words.
- FSM states:
  - IDLE: no word held.
  - W1: first word of a two-word byte held.
  - WL: last word held.
- Transitions:
  - Accept in IDLE -> W1 if 2 words needed, else WL.
  - W1 & out_ready -> WL, loading the word-2 indices from the internal pending register.
  - WL & out_ready -> IDLE, or directly to W1/WL if a new byte is accepted the same cycle.
- in_ready = (state==IDLE) | (state==WL & out_ready). This gives 1 byte/cycle throughput for one-word bytes.
- in_ready is 0 in W1.
- Latency: byte accepted on edge N -> out_valid=1 after edge N.
- out_last = 1 in WL, 0 in W1. out_valid = (state!=IDLE).
- Output holding rule: while out_valid=1 and out_ready=0, ind0..ind3 and out_last stay stable.
- in_data is sampled only on in_valid & in_ready.
- Reset mid-byte (e.g. in W1): the pending word 2 is discarded and the block returns to the reset values.

Optional Feature:
ECS3_ENC_STATS_EN:
- When defined, adds outputs byte_count[CNT_W-1:0] and split_count[CNT_W-1:0].
  - byte_count: bytes accepted.
  - split_count: bytes that needed two words.
- Both counters saturate at all-ones and reset to 0 on rst_n.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Reset, then byte 0x5A with out_ready=1 -> one word: ind0=110, ind1=000, ind2=001, ind3=011, out_last=1, 1 cycle after accept.
- Byte 0x07 -> word 1: ind0=001, ind1=010, ind2=000, ind3=000, out_last=0; word 2: ind0=011, others 000, out_last=1; in_ready=0 during word 1.
- Byte 0xFF -> word 1: 101/010/101/010; word 2: 011/000/011/000, out_last=1. The OR of the decoded words = 0xFF.
- Back-to-back bytes 0x00, 0x81, 0x3C with out_ready=1 -> three single-word outputs on consecutive cycles; in_ready stays 1.
- out_ready=0 for 5 cycles on a W1 word of 0x77 -> outputs stable, in_ready=0. Release -> word 2 follows, then IDLE.
- Assert rst_n=0 while in W1 for 0x70 -> out_valid=0 immediately. After release, byte 0x01 produces a single word: ind0=001, others 000.
